// File: rtl/stream_arb_mux_if.sv
// Stream bundle for stream_arb_mux: NCH valid/ready input channels feeding
// one registered valid/ready output. The master modport is the traffic source
// and sink side. The slave modport is the multiplexer itself.
interface stream_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  out_valid, out_data, out_last, out_sel,
    output out_ready
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output out_valid, out_data, out_last, out_sel,
    input  out_ready
  );
endinterface

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output.
// Arbitration is round-robin (RR=1) or fixed lowest-index priority (RR=0).
// Once a beat without last is accepted, the grant locks to that channel until
// its last beat is accepted. The round-robin pointer moves only at packet end.
module stream_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 2,
  parameter int RR    = 1
) (
  input logic          clock,
  input logic          reset_,
  stream_arb_mux_if.slave bus
);

  localparam logic [SEL_W:0]   NCH_X = (SEL_W+1)'(NCH);
  localparam logic [SEL_W-1:0] MAX_CH = SEL_W'(NCH - 1);

  // arbitration state
  logic [SEL_W-1:0] ptr;
  logic             lock;
  logic [SEL_W-1:0] lock_ch;

  // output register
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [SEL_W-1:0] out_sel_q;

  // combinational grant
  logic             load;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W:0]   scan_sum;
  logic [SEL_W-1:0] scan_idx;
  logic             take;
  logic             gnt_last;
  logic [SEL_W-1:0] next_ptr;
  logic [NCH-1:0]   ready;

  logic [WIDTH-1:0] ch_data [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_split
    assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // The output register can take a beat when it is empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

  // Pick the candidate channel. A locked grant waits on its own channel even
  // when it is idle, which shows up as a bubble on the output.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (lock) begin
      gnt_found = bus.in_valid[lock_ch];
      gnt_idx   = lock_ch;
    end else if (RR != 0) begin
      for (int k = 0; k < NCH; k++) begin
        scan_sum = {1'b0, ptr} + (SEL_W+1)'(k);
        if (scan_sum >= NCH_X) begin
          scan_sum = scan_sum - NCH_X;
        end
        scan_idx = scan_sum[SEL_W-1:0];
        if (!gnt_found && bus.in_valid[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = scan_idx;
        end
      end
    end else begin
      // Scan from the top down so the lowest valid index is the last one written.
      for (int k = NCH - 1; k >= 0; k--) begin
        scan_idx = SEL_W'(k);
        if (bus.in_valid[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = scan_idx;
        end
      end
    end
  end

  // Drive a single ready bit toward the granted channel. All bits stay low during reset.
  always_comb begin
    ready = '0;
    if (reset_ && gnt_found && load) begin
      ready[gnt_idx] = 1'b1;
    end
  end

  assign bus.in_ready = ready;
  assign take         = reset_ && gnt_found && load;
  assign gnt_last     = bus.in_last[gnt_idx];
  assign next_ptr     = (gnt_idx == MAX_CH) ? '0 : gnt_idx + SEL_W'(1);

  // Track packet lock and advance the round-robin pointer on accepted last beats.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ptr     <= '0;
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (take) begin
      if (!gnt_last) begin
        lock    <= 1'b1;
        lock_ch <= gnt_idx;
      end else begin
        lock <= 1'b0;
        if (RR != 0) begin
          ptr <= next_ptr;
        end
      end
    end
  end

  // Output register: load the granted beat, go empty when nothing is offered,
  // and hold everything while the sink stalls.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (take) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ch_data[gnt_idx];
        out_last_q  <= gnt_last;
        out_sel_q   <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux. It drives a round-robin instance (bus)
// and a fixed-priority instance (bus2) that share the same clock and reset.
module tb_stream_arb_mux;

  logic clock;
  logic reset_;
  int   n_chk;
  int   n_err;

  stream_arb_mux_if #(.WIDTH(32), .NCH(4), .SEL_W(2)) bus ();
  stream_arb_mux_if #(.WIDTH(32), .NCH(4), .SEL_W(2)) bus2 ();

  stream_arb_mux #(.WIDTH(32), .NCH(4), .SEL_W(2), .RR(1)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  stream_arb_mux #(.WIDTH(32), .NCH(4), .SEL_W(2), .RR(0)) dut_fp (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] d, input logic l);
    bus.in_data[ch*32 +: 32] = d;
    bus.in_last[ch]          = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, bus.out_valid, v);
    chk({tag, ".sel"},   bus.out_sel,   s);
    chk({tag, ".data"},  bus.out_data,  d);
    chk({tag, ".last"},  bus.out_last,  l);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_         = 1'b0;
    bus.in_valid   = 4'hF;
    bus.in_data    = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    bus.in_last    = 4'hF;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 4'h0;
    bus2.in_data   = '0;
    bus2.in_last   = 4'hF;
    bus2.out_ready = 1'b1;

    // Reset is held with every channel valid.
    #2;
    chk("rst.in_ready", bus.in_ready, 4'h0);
    chk_out("rst", 1'b0, 2'd0, 32'h0, 1'b0);
    #20;
    reset_       = 1'b1;
    bus.in_valid = 4'h0;
    tick();
    chk("post_rst.valid", bus.out_valid, 1'b0);

    // A single stream on ch2 with two one-beat packets.
    bus.in_valid = 4'b0100;
    set_ch(2, 32'hABCDEF01, 1'b1);
    #1 chk("single.in_ready", bus.in_ready, 4'b0100);
    tick();
    chk_out("single0", 1'b1, 2'd2, 32'hABCDEF01, 1'b1);
    set_ch(2, 32'h10FEDCBA, 1'b1);
    tick();
    chk_out("single1", 1'b1, 2'd2, 32'h10FEDCBA, 1'b1);
    bus.in_valid = 4'b0000;
    tick();
    chk_out("single_idle", 1'b0, 2'd2, 32'h10FEDCBA, 1'b1);

    // Reset asserted mid-packet: the lock is abandoned and the pointer goes back to 0.
    bus.in_valid = 4'b0010;
    set_ch(1, 32'h11110001, 1'b0);
    tick();
    chk_out("midpkt", 1'b1, 2'd1, 32'h11110001, 1'b0);
    bus.in_valid = 4'b0001;
    set_ch(0, 32'h000000C0, 1'b1);
    #1 chk("midpkt.locked_ready", bus.in_ready, 4'b0000);
    reset_ = 1'b0;
    #1;
    chk("midrst.valid", bus.out_valid, 1'b0);
    chk("midrst.in_ready", bus.in_ready, 4'b0000);
    reset_ = 1'b1;

    // Round robin with every channel valid and one-beat packets.
    bus.in_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_ch(i, 32'hC0 + i, 1'b1);
    #1 chk("rr.in_ready", bus.in_ready, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 32'hC0 + (i % 4), 1'b1);
    end
    bus.in_valid = 4'h0;
    tick();
    chk("rr_idle.valid", bus.out_valid, 1'b0);

    // Packet lock. ch0 sends one beat first so that ch1 is next in the rotation.
    bus.in_valid = 4'b0001;
    set_ch(0, 32'h000000D0, 1'b1);
    tick();
    chk_out("lk_pre", 1'b1, 2'd0, 32'h000000D0, 1'b1);
    bus.in_valid = 4'b0011;
    set_ch(1, 32'h000000B1, 1'b0);
    #1 chk("lk.ready1", bus.in_ready, 4'b0010);
    tick();
    chk_out("lk_b1", 1'b1, 2'd1, 32'h000000B1, 1'b0);
    bus.in_valid = 4'b0001;
    #1 chk("lk.ready_bubble", bus.in_ready, 4'b0000);
    tick();
    chk("lk_bubble.valid", bus.out_valid, 1'b0);
    bus.in_valid = 4'b0011;
    set_ch(1, 32'h000000B2, 1'b0);
    #1 chk("lk.ready2", bus.in_ready, 4'b0010);
    tick();
    chk_out("lk_b2", 1'b1, 2'd1, 32'h000000B2, 1'b0);
    set_ch(1, 32'h000000B3, 1'b1);
    #1 chk("lk.ready3", bus.in_ready, 4'b0010);
    tick();
    chk_out("lk_b3", 1'b1, 2'd1, 32'h000000B3, 1'b1);
    bus.in_valid = 4'b0001;
    #1 chk("lk.ready_ch0", bus.in_ready, 4'b0001);
    tick();
    chk_out("lk_ch0", 1'b1, 2'd0, 32'h000000D0, 1'b1);

    // Backpressure: a three-cycle stall while ch0 keeps offering its next beat.
    set_ch(0, 32'h10FEDE01, 1'b1);
    tick();
    chk_out("bp_load", 1'b1, 2'd0, 32'h10FEDE01, 1'b1);
    bus.out_ready = 1'b0;
    set_ch(0, 32'h00000E02, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp_stall%0d.in_ready", i), bus.in_ready, 4'b0000);
      tick();
      chk_out($sformatf("bp_stall%0d", i), 1'b1, 2'd0, 32'h10FEDE01, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_resume.in_ready", bus.in_ready, 4'b0001);
    tick();
    chk_out("bp_next", 1'b1, 2'd0, 32'h00000E02, 1'b1);
    bus.in_valid = 4'h0;
    tick();
    chk("bp_drain.valid", bus.out_valid, 1'b0);

    // Fixed priority with ch1 and ch3 both valid.
    bus2.in_valid = 4'b1010;
    bus2.in_data[1*32 +: 32] = 32'h00000021;
    bus2.in_data[3*32 +: 32] = 32'h00000023;
    #1 chk("fp.in_ready", bus2.in_ready, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fp%0d.valid", i), bus2.out_valid, 1'b1);
      chk($sformatf("fp%0d.sel", i), bus2.out_sel, 2'd1);
      chk($sformatf("fp%0d.data", i), bus2.out_data, 32'h00000021);
    end
    bus2.in_valid = 4'b1000;
    #1 chk("fp.in_ready3", bus2.in_ready, 4'b1000);
    tick();
    chk("fp_ch3.valid", bus2.out_valid, 1'b1);
    chk("fp_ch3.sel", bus2.out_sel, 2'd3);
    chk("fp_ch3.data", bus2.out_data, 32'h00000023);
    bus2.in_valid = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
Parametrised N-channel streaming multiplexer for the CPU datapath and its memory/writeback paths.
- Selects one of NCH valid/ready input streams and forwards it through a single registered output stage.
- Arbitration is round-robin or fixed-priority.
- Packet locking holds the grant until the current packet's last beat.
- Replaces ad-hoc 2:1 select muxes wherever sources contend for one sink and need backpressure.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NCH, 4, number of input channels (2..16).
- SEL_W, 2, width of out_sel; must equal ceil(log2(NCH)), minimum 1.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clock  input  1  rising-edge clock.
- reset_  input  1  asynchronous, active-low reset.
- in_valid  input  NCH  per-channel valid.
- in_data  input  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- in_last  input  NCH  per-channel end-of-packet marker.
- in_ready  output  NCH  per-channel ready (combinational from state and out_ready).
- out_valid  output  1  output beat valid (registered).
- out_data  output  WIDTH  output beat data (registered).
- out_last  output  1  end-of-packet of the output beat (registered).
- out_sel  output  SEL_W  source channel index of the output beat (registered).
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (reset_ low, asynchronous), all of the following are 0:
  - out_valid, out_data, out_last, out_sel;
  - rr pointer, lock flag, lock channel.
  - in_ready is forced to all 0 while reset_ is low.
- Transfers:
  - An input transfer occurs on a clock edge where in_valid[i] and in_ready[i] are both 1.
  - An output transfer occurs where out_valid and out_ready are both 1.
- Load enable: load = !out_valid || out_ready. The output register accepts a new beat only when load is 1.
- Grant, computed combinationally each cycle:
  - Locked: candidate is the lock channel only. Other channels see in_ready=0 even if the lock channel is idle, which produces a bubble on the output.
  - Unlocked, RR=1: candidate is the first channel with in_valid=1, searching from index ptr upward and wrapping modulo NCH.
  - Unlocked, RR=0: candidate is the lowest index with in_valid=1.
  - in_ready[g] = load for the granted channel g; all other bits are 0. At most one in_ready bit is high.
- On an input transfer from channel g:
  - out_data<=in_data[g], out_sel<=g, out_last<=in_last[g], out_valid<=1.
  - If in_last[g]=0: lock<=1, lock channel<=g.
  - If in_last[g]=1: lock<=0, and when RR=1, ptr<=(g+1) mod NCH. ptr advances only at packet end.
- No input transfer while load=1: out_valid<=0; out_data/out_sel/out_last keep their values.
- Load=0 (stall, out_valid=1 and out_ready=0): all output registers hold stable.
- Timing:
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 beat/cycle with out_ready held at 1; no bubble between consecutive beats of the same or different channels.
- Single-beat packets are beats with in_last=1 and no lock; they take no state beyond the ptr update.
- Reset mid-packet clears lock and ptr; the partially forwarded packet is abandoned and downstream sees no out_last.
- in_valid of a non-granted channel may drop at any time without effect. The source must keep its data stable until the transfer (standard valid/ready contract).

Test Plan:
- Reset: hold reset_ low with in_valid=4'hF → in_ready=0, out_valid=0, out_data=0, out_sel=0. Release at 22 ns; the first out_valid appears at the second rising clock edge after release.
- Single stream: ch2 sends 32'hABCDEF01 then 32'h10FEDCBA, last=1 each, out_ready=1 → out_valid high for 2 consecutive cycles, 1 cycle after each accept, with out_sel=2 and data in order.
- Round-robin (RR=1): all four channels continuously valid with single-beat packets (last=1) → out_sel sequence 0,1,2,3,0,1 with no idle cycle.
- Packet lock: ch1 sends a 3-beat packet (last on beat 3), dropping valid for 1 cycle after beat 1, while ch0 stays valid throughout → out_sel 1, bubble, 1, 1 (last=1), then 0. ch0's in_ready stays 0 until ch1's last beat is accepted.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with data 32'h10FEDE01 → out_data/out_sel/out_last stable and all in_ready 0. After out_ready returns, the sequence has no lost or duplicated beat.
- Fixed priority (RR=0): ch1 and ch3 continuously valid with single beats → out_sel=1 every cycle and ch3 never granted. When ch1 drops valid, ch3 is granted the next cycle.
